// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: DEPTH-entry byte FIFO feeding a serializer, DIV clocks per bit.
// Latency: a write into an empty idle buffer drives the start bit one edge later; writes while full drop unless that edge pops.
module uart_tx_buf #(
    parameter int DEPTH = 16,
    parameter int DIV0  = 5208,
    parameter int DIV1  = 2604,
    parameter int DIV2  = 868,
    parameter int DIV3  = 434
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               baud_setting,
    input  logic [7:0]               tx_data,
    input  logic                     tx_req,
    output logic                     tx,
    output logic                     tx_busy,
    output logic                     tx_done,
    output logic                     tx_full,
    output logic                     tx_empty,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic                     tx_overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_nxt;
    logic          push, pop;

    state_t        state, state_nxt;
    logic [15:0]   cnt, cnt_nxt;
    logic [15:0]   div_q, div_nxt, div_sel;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          tx_nxt, done_nxt, bit_end;

    always_comb begin
        div_sel = 16'(DIV3);
        case (baud_setting)
            2'd0:    div_sel = 16'(DIV0);
            2'd1:    div_sel = 16'(DIV1);
            2'd2:    div_sel = 16'(DIV2);
            default: div_sel = 16'(DIV3);
        endcase
    end

    assign bit_end = (cnt == div_q - 16'd1);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 16'd1;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        div_nxt     = div_q;
        pop         = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!tx_empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                    shift_nxt = mem[rd_ptr];
                    div_nxt   = div_sel;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nxt     = '0;
                    shift_nxt   = {1'b0, shift[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_nxt  = '0;
                    done_nxt = 1'b1;
                    // Chain straight into the next start bit so queued bytes leave with no idle gap.
                    if (!tx_empty) begin
                        pop       = 1'b1;
                        state_nxt = START;
                        shift_nxt = mem[rd_ptr];
                        div_nxt   = div_sel;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    // A full FIFO still takes a write on an edge that pops, since a slot frees up at that edge.
    assign push      = tx_req && (!tx_full || pop);
    assign count_nxt = tx_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign tx_busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            div_q       <= 16'(DIV3);
            bit_idx     <= '0;
            shift       <= '0;
            tx          <= 1'b1;
            tx_done     <= 1'b0;
            tx_overflow <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tx_count    <= '0;
            tx_full     <= 1'b0;
            tx_empty    <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            div_q       <= div_nxt;
            bit_idx     <= bit_idx_nxt;
            shift       <= shift_nxt;
            tx          <= tx_nxt;
            tx_done     <= done_nxt;
            tx_overflow <= tx_req && tx_full && !pop;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            tx_count    <= count_nxt;
            tx_full     <= (count_nxt == (AW+1)'(DEPTH));
            tx_empty    <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_data;
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Randomized bench for uart_tx_buf against a frame-timeline reference model.
module tb_uart_tx_buf;

    localparam int DEPTH = 16;
    localparam int D0 = 23, D1 = 11, D2 = 2, D3 = 5;

    logic       clk;
    logic       rst;
    logic [1:0] baud_setting;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx, tx_busy, tx_done, tx_full, tx_empty, tx_overflow;
    logic [4:0] tx_count;

    uart_tx_buf #(.DEPTH(DEPTH), .DIV0(D0), .DIV1(D1), .DIV2(D2), .DIV3(D3)) dut (
        .clk(clk), .rst(rst), .baud_setting(baud_setting), .tx_data(tx_data),
        .tx_req(tx_req), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_full(tx_full), .tx_empty(tx_empty), .tx_count(tx_count),
        .tx_overflow(tx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: queued bytes plus the timeline of the frame on the line.
    logic [7:0] q[$];
    bit         active = 0;
    int         s = 0, d = 1, n = 0;
    logic [7:0] b = 8'h00;
    bit         done_exp = 0, ovf_exp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    function automatic int div_of(input logic [1:0] bs);
        case (bs)
            2'd0:    return D0;
            2'd1:    return D1;
            2'd2:    return D2;
            default: return D3;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        active   = 0;
        done_exp = 0;
        ovf_exp  = 0;
    endtask

    task automatic model_step();
        int sz;
        bit ended, popd, accept;
        sz       = q.size();
        ended    = active && (n == s + 10 * d);
        popd     = (!active || ended) && (sz > 0);
        done_exp = ended;
        if (popd) begin
            s = n;
            b = q.pop_front();
            d = div_of(baud_setting);
            active = 1;
        end else if (ended) begin
            active = 0;
        end
        accept  = tx_req && ((sz < DEPTH) || popd);
        ovf_exp = tx_req && !accept;
        if (accept)
            q.push_back(tx_data);
    endtask

    task automatic check_all();
        logic exp_tx;
        int   bi;
        exp_tx = 1'b1;
        if (active) begin
            bi = (n - s) / d;
            if (bi == 0)
                exp_tx = 1'b0;
            else if (bi <= 8)
                exp_tx = b[bi-1];
        end
        chk("tx",       32'(tx),          32'(exp_tx));
        chk("busy",     32'(tx_busy),     32'(active));
        chk("done",     32'(tx_done),     32'(done_exp));
        chk("overflow", 32'(tx_overflow), 32'(ovf_exp));
        chk("count",    32'(tx_count),    32'(q.size()));
        chk("full",     32'(tx_full),     32'(q.size() == DEPTH));
        chk("empty",    32'(tx_empty),    32'(q.size() == 0));
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        if (rst)
            model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic write(input logic [7:0] v);
        tx_req  = 1'b1;
        tx_data = v;
        tick();
        tx_req  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20000 && (q.size() > 0 || active); i++)
            tick();
        tick();
        chk("drain_busy",  32'(tx_busy),  32'd0);
        chk("drain_empty", 32'(tx_empty), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; tx_req = 1'b0; tx_data = 8'h00; baud_setting = 2'd3;
        #1 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Single byte, then three back-to-back bytes.
        write(8'hA5);
        drain();
        write(8'h00);
        write(8'hFF);
        write(8'h55);
        drain();

        // Overfill while busy, then keep writing so a pop edge accepts while full.
        for (int i = 0; i < 20; i++)
            write(8'(i * 7 + 1));
        for (int i = 0; i < 60; i++)
            write(8'($urandom));
        drain();

        // Baud change mid-frame only affects the following frame.
        write(8'h3C);
        write(8'hC3);
        for (int i = 0; i < 20; i++)
            tick();
        baud_setting = 2'd0;
        drain();

        // Fill, drain and refill through pointer wrap at the fastest rate.
        baud_setting = 2'd2;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH + 1; i++)
                write(8'($urandom));
            drain();
        end

        // Random traffic with occasional baud changes.
        for (int i = 0; i < 3000; i++) begin
            tx_req  = ($urandom_range(0, 3) == 0);
            tx_data = 8'($urandom);
            if ($urandom_range(0, 99) == 0)
                baud_setting = 2'($urandom_range(0, 3));
            tick();
        end
        tx_req = 1'b0;
        drain();

        // Reset mid-DATA with bytes queued, then resume.
        baud_setting = 2'd3;
        for (int i = 0; i < 5; i++)
            write(8'($urandom));
        for (int i = 0; i < 15; i++)
            tick();
        chk("pre_reset_busy", 32'(tx_busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        tick();
        rst = 1'b1;
        write(8'h96);
        chk("post_reset_count", 32'(tx_count), 32'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
